// File: rtl/vector_capture.sv
// vector_capture: records {stimulus, response} pairs from a unit under test
// into a small vector memory and streams them back, in capture order, over a
// valid/ready port. The packed word layout {sample_in, sample_out} matches the
// layout the vector-file checkers read, so a dump can be replayed as a golden
// .tv file.

module vector_capture #(
    parameter int IN_W  = 1,
    parameter int OUT_W = 1,
    parameter int DEPTH = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    sample_valid,
    input  logic [IN_W-1:0]         sample_in,
    input  logic [OUT_W-1:0]        sample_out,
    input  logic                    dump_start,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [IN_W+OUT_W-1:0]   out_data,
    output logic                    out_last,
    output logic [8:0]              count,
    output logic                    busy,
    output logic                    full,
    output logic                    overflow,
    output logic                    done
);

    localparam int WORD_W = IN_W + OUT_W;
    // Address width wide enough for DEPTH entries; a single-entry memory
    // still needs one address bit so the slices below stay legal.
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_C = 9'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2,
        ST_DUMP    = 2'd3
    } state_t;

    // Vector storage; deliberately not reset so a capture survives a reset.
    logic [WORD_W-1:0] mem_r [0:DEPTH-1];

    state_t            state_r;
    state_t            state_s;
    logic [8:0]        count_r;
    logic [8:0]        count_s;
    logic [8:0]        rd_ptr_r;
    logic [8:0]        rd_ptr_s;
    logic              overflow_r;
    logic              overflow_s;
    logic              busy_r;
    logic              done_r;
    logic              full_r;
    logic              out_valid_r;

    logic              wr_en_s;
    logic [WORD_W-1:0] wr_word_s;
    logic [WORD_W-1:0] rd_word_s;
    logic              last_s;
    logic              xfer_s;

    assign wr_word_s = {sample_in, sample_out};

    // Read side: the word under rd_ptr, forced to zero outside a dump.
    always_comb begin
        rd_word_s = {WORD_W{1'b0}};
        last_s    = 1'b0;
        if (out_valid_r) begin
            rd_word_s = mem_r[rd_ptr_r[ADDR_W-1:0]];
            last_s    = (rd_ptr_r == (count_r - 9'd1));
        end else begin
            rd_word_s = {WORD_W{1'b0}};
            last_s    = 1'b0;
        end
    end

    // A word leaves only while it is being presented and downstream accepts.
    assign xfer_s = out_valid_r & out_ready;

    // Next-state logic: capture, close, dump and restart decisions.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        rd_ptr_s   = rd_ptr_r;
        overflow_s = overflow_r;
        wr_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_CAPTURE;
                    count_s = 9'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (start) begin
                    // Restart drops any sample offered in the same cycle.
                    state_s = ST_CAPTURE;
                    count_s = 9'd0;
                end else begin
                    if (sample_valid && (count_r < DEPTH_C)) begin
                        wr_en_s = 1'b1;
                        count_s = count_r + 9'd1;
                    end else begin
                        count_s = count_r;
                    end
                    // A sample coinciding with stop is kept before closing.
                    if (stop || (count_s == DEPTH_C)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CAPTURE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s    = ST_CAPTURE;
                    count_s    = 9'd0;
                    overflow_s = 1'b0;
                end else begin
                    if (sample_valid) begin
                        overflow_s = 1'b1;
                    end else begin
                        overflow_s = overflow_r;
                    end
                    // An empty capture has nothing to stream.
                    if (dump_start && (count_r != 9'd0)) begin
                        state_s  = ST_DUMP;
                        rd_ptr_s = 9'd0;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
            end
            ST_DUMP: begin
                if (xfer_s) begin
                    rd_ptr_s = rd_ptr_r + 9'd1;
                    if (last_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_DUMP;
                    end
                end else begin
                    rd_ptr_s = rd_ptr_r;
                    state_s  = ST_DUMP;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                count_s    = 9'd0;
                rd_ptr_s   = 9'd0;
                overflow_s = 1'b0;
            end
        endcase
    end

    // State, pointers and output flags; flags are registered from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            count_r     <= 9'd0;
            rd_ptr_r    <= 9'd0;
            overflow_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            full_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            rd_ptr_r    <= rd_ptr_s;
            overflow_r  <= overflow_s;
            busy_r      <= (state_s == ST_CAPTURE) || (state_s == ST_DUMP);
            done_r      <= (state_s == ST_DONE);
            full_r      <= (count_s == DEPTH_C);
            out_valid_r <= (state_s == ST_DUMP);
        end
    end

    // Memory write port; suppressed during reset so reset never stores data.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_r[count_r[ADDR_W-1:0]] <= wr_word_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = rd_word_s;
    assign out_last  = last_s;
    assign count     = count_r;
    assign busy      = busy_r;
    assign full      = full_r;
    assign overflow  = overflow_r;
    assign done      = done_r;

endmodule

// File: tb/tb_vector_capture.sv
// Self-checking bench for vector_capture: directed scenarios followed by
// random traffic, all compared every cycle against a queue-based model.

module tb_vector_capture;

    localparam int DEPTH = 11;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       sample_valid;
    logic [0:0] sample_in;
    logic [0:0] sample_out;
    logic       dump_start;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic       out_last;
    logic [8:0] count;
    logic       busy;
    logic       full;
    logic       overflow;
    logic       done;

    vector_capture #(.IN_W(1), .OUT_W(1), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_out   (sample_out),
        .dump_start   (dump_start),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .count        (count),
        .busy         (busy),
        .full         (full),
        .overflow     (overflow),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Reference model: operating mode, captured words in order, read index.
    localparam int M_IDLE = 0;
    localparam int M_CAP  = 1;
    localparam int M_DONE = 2;
    localparam int M_DUMP = 3;
    int         m_mode = M_IDLE;
    logic [1:0] m_q[$];
    int         m_rd   = 0;
    bit         m_ovf  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [1:0] e_data;
        logic       e_last;
        e_data = 2'b00;
        e_last = 1'b0;
        if (m_mode == M_DUMP) begin
            e_data = m_q[m_rd];
            e_last = (m_rd == m_q.size() - 1);
        end
        check("out_valid", {31'd0, out_valid}, {31'd0, (m_mode == M_DUMP)});
        check("out_data",  {30'd0, out_data},  {30'd0, e_data});
        check("out_last",  {31'd0, out_last},  {31'd0, e_last});
        check("count",     {23'd0, count},     m_q.size());
        check("busy",      {31'd0, busy},      {31'd0, (m_mode == M_CAP) || (m_mode == M_DUMP)});
        check("full",      {31'd0, full},      {31'd0, (m_q.size() == DEPTH)});
        check("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
        check("done",      {31'd0, done},      {31'd0, (m_mode == M_DONE)});
    endtask

    task automatic model_step(input logic r, st, sp, sv, si, so, ds, rdy);
        if (r) begin
            m_mode = M_IDLE;
            m_q.delete();
            m_rd   = 0;
            m_ovf  = 1'b0;
        end else if (m_mode == M_IDLE) begin
            if (st) m_mode = M_CAP;
        end else if (m_mode == M_CAP) begin
            if (st) begin
                m_q.delete();
            end else begin
                if (sv) begin
                    m_q.push_back({si, so});
                    if (m_q.size() == DEPTH) m_mode = M_DONE;
                end
                if (sp) m_mode = M_DONE;
            end
        end else if (m_mode == M_DONE) begin
            if (st) begin
                m_q.delete();
                m_ovf  = 1'b0;
                m_mode = M_CAP;
            end else begin
                if (sv) m_ovf = 1'b1;
                if (ds && m_q.size() > 0) begin
                    m_mode = M_DUMP;
                    m_rd   = 0;
                end
            end
        end else begin
            if (rdy) begin
                if (m_rd == m_q.size() - 1) m_mode = M_DONE;
                else m_rd++;
            end
        end
    endtask

    // One clock: compare at negedge, drive, clock, advance the model.
    task automatic step(input logic r, st, sp, sv, si, so, ds, rdy);
        @(negedge clk);
        if (cmp_en) compare_all();
        reset        = r;
        start        = st;
        stop         = sp;
        sample_valid = sv;
        sample_in    = si;
        sample_out   = so;
        dump_start   = ds;
        out_ready    = rdy;
        @(posedge clk);
        model_step(r, st, sp, sv, si, so, ds, rdy);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
        sample_in = 1'b0; sample_out = 1'b0; dump_start = 1'b0; out_ready = 1'b0;

        //          r  st sp sv si so ds rdy
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {30'd0, out_data},  32'd0);
        check("rst_count",     {23'd0, count},     32'd0);
        check("rst_done",      {31'd0, done},      32'd0);

        // Basic capture and dump: (1,0), (0,1), (1,0)+stop.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("basic_count", {23'd0, count}, 32'd3);
        check("basic_done",  {31'd0, done},  32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check("basic_w1", {30'd0, out_data}, 32'd2);
        check("basic_l1", {31'd0, out_last}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("basic_w2", {30'd0, out_data}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("basic_w3", {30'd0, out_data}, 32'd2);
        check("basic_l3", {31'd0, out_last}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("basic_end_done",  {31'd0, done},      32'd1);
        check("basic_end_valid", {31'd0, out_valid}, 32'd0);

        // Fill to depth, then one sample too many.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        end
        #1;
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_done", {31'd0, done}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("fill_overflow", {31'd0, overflow}, 32'd1);
        check("fill_count",    {23'd0, count},    32'd11);

        // Restart clears overflow and count.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("restart_overflow", {31'd0, overflow}, 32'd0);
        check("restart_count",    {23'd0, count},    32'd0);
        check("restart_busy",     {31'd0, busy},     32'd1);

        // Backpressure: three words, ready pattern 1,0,0,1,1.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("bp_hold_w2", {30'd0, out_data}, 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("bp_done", {31'd0, done}, 32'd1);

        // Empty dump is ignored.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check("empty_valid", {31'd0, out_valid}, 32'd0);
        check("empty_done",  {31'd0, done},      32'd1);

        // Reset during word 2 of a dump, then a fresh one-word capture.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("rstdump_valid", {31'd0, out_valid}, 32'd0);
        check("rstdump_count", {23'd0, count},     32'd0);
        check("rstdump_done",  {31'd0, done},      32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("rstdump_word", {30'd0, out_data}, 32'd1);
        check("rstdump_last", {31'd0, out_last}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            step(1'($urandom_range(99) < 2),
                 1'($urandom_range(99) < 5),
                 1'($urandom_range(99) < 5),
                 1'($urandom_range(99) < 50),
                 1'($urandom),
                 1'($urandom),
                 1'($urandom_range(99) < 15),
                 1'($urandom_range(99) < 60));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
